// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   arb_port_t  : requesting port identifiers (PORT_IF, PORT_DM)
//   TAM_*       : access-size encodings carried on dm_tam / mem_tam
//   cnt_width() : bit width needed by the wait counter for a given MEM_LAT
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } arb_port_t;

    // Size encodings are opaque to the arbiter; fetches always use TAM_IF.
    localparam logic [1:0] TAM_BYTE  = 2'b00;
    localparam logic [1:0] TAM_HALF  = 2'b01;
    localparam logic [1:0] TAM_WORD  = 2'b10;
    localparam logic [1:0] TAM_DWORD = 2'b11;
    localparam logic [1:0] TAM_IF    = 2'b00;

    // The counter holds values 0 .. lat-1, so it needs clog2(lat) bits,
    // with a floor of one bit for the single-cycle memory.
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// ---------------------------------------------------------------------------
// arb_wait_counter
// Loadable down-counter that times the memory access window.
// Ports:
//   clk        in  clock, rising edge
//   Reset_n    in  asynchronous active-low reset
//   load       in  load load_value this edge (takes priority over counting)
//   load_value in  value to load (MEM_LAT-1 from the arbiter)
//   count      out current count
//   done       out count has reached zero
// ---------------------------------------------------------------------------
module arb_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port unified memory between instruction fetch (IF) and
// the load/store path (DM). One request is accepted at a time; the memory is
// driven for MEM_LAT cycles, then read data or a store ack is returned.
//
// Parameters: AW address width, DW data width, MEM_LAT access cycles (>=1).
// Ports:
//   clk, Reset_n                       clock / async active-low reset
//   if_req, if_addr                    fetch request (held until if_gnt)
//   if_gnt, if_rvalid, if_rdata        fetch grant pulse, response pulse, data
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_tam                   data request (held until dm_gnt)
//   dm_gnt, dm_rvalid, dm_rdata        data grant pulse, response pulse, data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_tam, mem_rdata      memory macro interface
//   busy                               high in ACCESS and RESP
//
// Build option: define ARB_RR_EN to resolve simultaneous requests
// round-robin; otherwise DM always wins a tie.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [1:0]    dm_tam,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_tam,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            CW       = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    arb_port_t     win;
    arb_port_t     cur_port;
    logic          cur_we;
    logic          any_req;
    logic          start_access;
    logic          first_cycle;
    logic [CW-1:0] wait_count;
    logic          wait_done;

    assign any_req = if_req | dm_req;

    // A new access can only be launched from IDLE or straight out of RESP.
    assign start_access = ((state_q == IDLE) || (state_q == RESP)) && any_req;

`ifdef ARB_RR_EN
    arb_port_t last_grant;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        win = PORT_IF;
        if (if_req && dm_req) begin
            win = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
        end else if (dm_req) begin
            win = PORT_DM;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant <= PORT_DM;
        end else if (start_access) begin
            last_grant <= win;
        end
    end
`else
    // Fixed priority: the data path always beats instruction fetch.
    always_comb begin
        win = dm_req ? PORT_DM : PORT_IF;
    end
`endif

    arb_wait_counter #(
        .WIDTH (CW)
    ) u_wait (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .load       (start_access),
        .load_value (LOAD_VAL),
        .count      (wait_count),
        .done       (wait_done)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (wait_done) state_d = RESP;
            RESP:    state_d = any_req ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requester inputs are latched at the arbitration edge so that later
    // changes on the request ports cannot disturb the memory mid-access.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_port  <= PORT_DM;
            cur_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_tam   <= '0;
        end else if (start_access) begin
            cur_port <= win;
            if (win == PORT_DM) begin
                cur_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_tam   <= dm_tam;
            end else begin
                cur_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_tam   <= TAM_IF;
            end
        end
    end

    // Read data is captured at the end of the last access cycle; stores
    // leave the DM data register untouched.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if ((state_q == ACCESS) && wait_done) begin
            if (cur_port == PORT_IF) begin
                if_rdata <= mem_rdata;
            end else if (!cur_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    // The counter still holds its load value only during the first access
    // cycle, which is when the grant and the write strobe are issued.
    assign first_cycle = (state_q == ACCESS) && (wait_count == LOAD_VAL);

    always_comb begin
        if_gnt    = first_cycle && (cur_port == PORT_IF);
        dm_gnt    = first_cycle && (cur_port == PORT_DM);
        if_rvalid = (state_q == RESP) && (cur_port == PORT_IF);
        dm_rvalid = (state_q == RESP) && (cur_port == PORT_DM);
        mem_en    = (state_q == ACCESS);
        mem_we    = first_cycle && cur_we;
        busy      = (state_q == ACCESS) || (state_q == RESP);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [1:0]    dm_tam;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    mem_tam;

    logic          l1_if_req, l1_if_gnt, l1_if_rvalid;
    logic [AW-1:0] l1_if_addr;
    logic [DW-1:0] l1_if_rdata;
    logic          l1_dm_req, l1_dm_we, l1_dm_gnt, l1_dm_rvalid;
    logic [AW-1:0] l1_dm_addr;
    logic [DW-1:0] l1_dm_wdata, l1_dm_rdata;
    logic [1:0]    l1_dm_tam;
    logic          l1_mem_en, l1_mem_we, l1_busy;
    logic [AW-1:0] l1_mem_addr;
    logic [DW-1:0] l1_mem_wdata, l1_mem_rdata;
    logic [1:0]    l1_mem_tam;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_tam(dm_tam), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_tam(mem_tam), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
        .clk(clk), .Reset_n(Reset_n),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
        .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
        .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
        .dm_tam(l1_dm_tam), .dm_gnt(l1_dm_gnt), .dm_rvalid(l1_dm_rvalid), .dm_rdata(l1_dm_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_tam(l1_mem_tam), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        isDm;
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  tam;
        logic [63:0] memData;
        logic [1:0]  expTam;
        logic [63:0] expIfRdata;
        logic [63:0] expDmRdata;
    } vec_t;

    vec_t vecs[5];

    task automatic checkBit(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one isolated transaction on the MEM_LAT=2 instance and checks
    // every cycle from grant through return to IDLE.
    task automatic applyStimulus(input int i, input vec_t v);
        logic winGnt, loseGnt, winVal, loseVal;
        @(negedge clk);
        if_req    = !v.isDm;
        dm_req    = v.isDm;
        if_addr   = v.addr;
        dm_addr   = v.addr;
        dm_we     = v.we;
        dm_wdata  = v.wdata;
        dm_tam    = v.tam;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;

        @(negedge clk);
        winGnt  = v.isDm ? dm_gnt : if_gnt;
        loseGnt = v.isDm ? if_gnt : dm_gnt;
        checkBit($sformatf("v%0d c1 gnt", i), winGnt, 1'b1);
        checkBit($sformatf("v%0d c1 other gnt", i), loseGnt, 1'b0);
        checkBit($sformatf("v%0d c1 mem_en", i), mem_en, 1'b1);
        checkBit($sformatf("v%0d c1 mem_we", i), mem_we, v.isDm & v.we);
        checkWord($sformatf("v%0d c1 mem_addr", i), 64'(mem_addr), 64'(v.addr));
        checkWord($sformatf("v%0d c1 mem_tam", i), 64'(mem_tam), 64'(v.expTam));
        if (v.isDm && v.we)
            checkWord($sformatf("v%0d c1 mem_wdata", i), mem_wdata, v.wdata);
        if_req  = 1'b0;
        dm_req  = 1'b0;
        dm_addr = 32'hDEAD_0000;
        if_addr = 32'hBEEF_0000;
        dm_tam  = ~v.tam;

        @(negedge clk);
        checkBit($sformatf("v%0d c2 gnt", i), if_gnt | dm_gnt, 1'b0);
        checkBit($sformatf("v%0d c2 mem_en", i), mem_en, 1'b1);
        checkBit($sformatf("v%0d c2 mem_we", i), mem_we, 1'b0);
        checkBit($sformatf("v%0d c2 rvalid", i), if_rvalid | dm_rvalid, 1'b0);
        checkWord($sformatf("v%0d c2 mem_addr held", i), 64'(mem_addr), 64'(v.addr));
        mem_rdata = v.memData;

        @(negedge clk);
        winVal  = v.isDm ? dm_rvalid : if_rvalid;
        loseVal = v.isDm ? if_rvalid : dm_rvalid;
        checkBit($sformatf("v%0d c3 rvalid", i), winVal, 1'b1);
        checkBit($sformatf("v%0d c3 other rvalid", i), loseVal, 1'b0);
        checkBit($sformatf("v%0d c3 mem_en", i), mem_en, 1'b0);
        checkBit($sformatf("v%0d c3 busy", i), busy, 1'b1);
        checkWord($sformatf("v%0d c3 if_rdata", i), if_rdata, v.expIfRdata);
        checkWord($sformatf("v%0d c3 dm_rdata", i), dm_rdata, v.expDmRdata);
        mem_rdata = 64'h0;

        @(negedge clk);
        checkBit($sformatf("v%0d c4 busy", i), busy, 1'b0);
        checkBit($sformatf("v%0d c4 rvalid", i), if_rvalid | dm_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic firstDm;
        logic fGnt, oGnt, fVal, oVal;
        logic [63:0] fExp, oExp;

        vecs[0] = '{isDm:1'b0, we:1'b0, addr:32'h100, wdata:64'h0, tam:2'b11,
                    memData:64'hDEAD, expTam:2'b00, expIfRdata:64'hDEAD, expDmRdata:64'h0};
        vecs[1] = '{isDm:1'b1, we:1'b1, addr:32'h40, wdata:64'h55, tam:2'b11,
                    memData:64'hBEEF, expTam:2'b11, expIfRdata:64'hDEAD, expDmRdata:64'h0};
        vecs[2] = '{isDm:1'b1, we:1'b0, addr:32'h80, wdata:64'h0, tam:2'b10,
                    memData:64'hCAFE, expTam:2'b10, expIfRdata:64'hDEAD, expDmRdata:64'hCAFE};
        vecs[3] = '{isDm:1'b1, we:1'b1, addr:32'h88, wdata:64'h77, tam:2'b01,
                    memData:64'h1111, expTam:2'b01, expIfRdata:64'hDEAD, expDmRdata:64'hCAFE};
        vecs[4] = '{isDm:1'b0, we:1'b0, addr:32'h104, wdata:64'h0, tam:2'b10,
                    memData:64'h1234_5678_9ABC_DEF0, expTam:2'b00,
                    expIfRdata:64'h1234_5678_9ABC_DEF0, expDmRdata:64'hCAFE};

        Reset_n   = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_tam = '0; mem_rdata = '0;
        l1_if_req = 1'b0; l1_if_addr = '0; l1_dm_req = 1'b0; l1_dm_we = 1'b0;
        l1_dm_addr = '0; l1_dm_wdata = '0; l1_dm_tam = '0; l1_mem_rdata = '0;

        repeat (3) @(negedge clk);
        checkWord("reset ctrl outputs",
                  64'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}), 64'h0);
        checkWord("reset mem_addr", 64'(mem_addr), 64'h0);
        checkWord("reset if_rdata", if_rdata, 64'h0);
        checkWord("reset dm_rdata", dm_rdata, 64'h0);
        Reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Reset asserted in the second access cycle of a DM load.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_tam = 2'b10;
        @(negedge clk);
        checkBit("rst seq dm_gnt", dm_gnt, 1'b1);
        dm_req = 1'b0;
        @(negedge clk);
        mem_rdata = 64'h9999;
        Reset_n   = 1'b0;
        #1;
        checkWord("rst seq ctrl outputs",
                  64'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}), 64'h0);
        checkWord("rst seq mem_addr", 64'(mem_addr), 64'h0);
        checkWord("rst seq mem_tam", 64'(mem_tam), 64'h0);
        checkWord("rst seq if_rdata", if_rdata, 64'h0);
        checkWord("rst seq dm_rdata", dm_rdata, 64'h0);
        @(negedge clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkBit($sformatf("rst seq post c%0d rvalid", c), dm_rvalid | if_rvalid, 1'b0);
            checkBit($sformatf("rst seq post c%0d busy", c), busy, 1'b0);
        end
        checkWord("rst seq post dm_rdata", dm_rdata, 64'h0);

        // Simultaneous requests, two rounds straight after reset.
`ifdef ARB_RR_EN
        firstDm = 1'b0;
`else
        firstDm = 1'b1;
`endif
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
            if_addr = 32'h300 + 32'(r); dm_addr = 32'h400 + 32'(r); dm_tam = 2'b01;
            @(negedge clk);
            fGnt = firstDm ? dm_gnt : if_gnt;
            oGnt = firstDm ? if_gnt : dm_gnt;
            checkBit($sformatf("tie r%0d first gnt", r), fGnt, 1'b1);
            checkBit($sformatf("tie r%0d other gnt c1", r), oGnt, 1'b0);
            checkWord($sformatf("tie r%0d first addr", r), 64'(mem_addr),
                      firstDm ? 64'(32'h400 + 32'(r)) : 64'(32'h300 + 32'(r)));
            if (firstDm) dm_req = 1'b0; else if_req = 1'b0;
            @(negedge clk);
            mem_rdata = 64'hA1 + 64'(r);
            @(negedge clk);
            fVal = firstDm ? dm_rvalid : if_rvalid;
            checkBit($sformatf("tie r%0d first rvalid", r), fVal, 1'b1);
            checkBit($sformatf("tie r%0d resp busy", r), busy, 1'b1);
            @(negedge clk);
            oGnt = firstDm ? if_gnt : dm_gnt;
            checkBit($sformatf("tie r%0d other gnt", r), oGnt, 1'b1);
            checkWord($sformatf("tie r%0d other addr", r), 64'(mem_addr),
                      firstDm ? 64'(32'h300 + 32'(r)) : 64'(32'h400 + 32'(r)));
            if_req = 1'b0; dm_req = 1'b0;
            @(negedge clk);
            mem_rdata = 64'hB1 + 64'(r);
            @(negedge clk);
            oVal = firstDm ? if_rvalid : dm_rvalid;
            checkBit($sformatf("tie r%0d other rvalid", r), oVal, 1'b1);
            fExp = 64'hA1 + 64'(r);
            oExp = 64'hB1 + 64'(r);
            checkWord($sformatf("tie r%0d if_rdata", r), if_rdata, firstDm ? oExp : fExp);
            checkWord($sformatf("tie r%0d dm_rdata", r), dm_rdata, firstDm ? fExp : oExp);
            @(negedge clk);
            checkBit($sformatf("tie r%0d idle", r), busy, 1'b0);
        end

        // Fetch request held across RESP: back-to-back accesses, no IDLE gap.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checkBit($sformatf("b2b c%0d if_gnt", c), if_gnt, (c % 3) == 1);
            checkBit($sformatf("b2b c%0d if_rvalid", c), if_rvalid, (c % 3) == 0);
            checkBit($sformatf("b2b c%0d busy", c), busy, 1'b1);
            if ((c % 3) == 0)
                checkWord($sformatf("b2b c%0d if_rdata", c), if_rdata, 64'hA000 + 64'(c - 1));
            if (c == 9) if_req = 1'b0;
            mem_rdata = 64'hA000 + 64'(c);
        end
        @(negedge clk);
        checkBit("b2b end busy", busy, 1'b0);
        checkBit("b2b end if_gnt", if_gnt, 1'b0);

        // Single-cycle memory: DM load.
        @(negedge clk);
        l1_dm_req = 1'b1; l1_dm_we = 1'b0; l1_dm_addr = 32'h8; l1_dm_tam = 2'b11;
        @(negedge clk);
        checkBit("lat1 dm_gnt", l1_dm_gnt, 1'b1);
        checkBit("lat1 mem_en", l1_mem_en, 1'b1);
        checkBit("lat1 c1 rvalid", l1_dm_rvalid, 1'b0);
        checkWord("lat1 mem_addr", 64'(l1_mem_addr), 64'h8);
        l1_dm_req    = 1'b0;
        l1_mem_rdata = 64'h1234;
        @(negedge clk);
        checkBit("lat1 dm_rvalid", l1_dm_rvalid, 1'b1);
        checkBit("lat1 c2 gnt", l1_dm_gnt, 1'b0);
        checkBit("lat1 c2 mem_en", l1_mem_en, 1'b0);
        checkWord("lat1 dm_rdata", l1_dm_rdata, 64'h1234);
        l1_mem_rdata = 64'h0;
        @(negedge clk);
        checkBit("lat1 idle busy", l1_busy, 1'b0);
        checkBit("lat1 idle rvalid", l1_dm_rvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
